// File: rtl/branch_target_buffer_if.sv
// Fetch/execute side bus of the branch target buffer.
// Master drives lookups and resolutions; slave returns predictions.
interface branch_target_buffer_if #(
  parameter int STAT_W = 16
);
  logic [31:0]       lookup_pc;
  logic              predict_hit;
  logic              predict_taken;
  logic [31:0]       predict_next_pc;
  logic              update_en;
  logic [31:0]       update_pc;
  logic              update_taken;
  logic [31:0]       update_target;
  logic              update_mispredict;
  logic              clear;
  logic [STAT_W-1:0] mispredict_cnt;

  modport master (
    output lookup_pc,
    output update_en,
    output update_pc,
    output update_taken,
    output update_target,
    output update_mispredict,
    output clear,
    input  predict_hit,
    input  predict_taken,
    input  predict_next_pc,
    input  mispredict_cnt
  );

  modport slave (
    input  lookup_pc,
    input  update_en,
    input  update_pc,
    input  update_taken,
    input  update_target,
    input  update_mispredict,
    input  clear,
    output predict_hit,
    output predict_taken,
    output predict_next_pc,
    output mispredict_cnt
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with saturating direction counters.
// Zero-latency lookup, trained from execute-stage resolutions.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic CLK,
  input  logic nRST,
  branch_target_buffer_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam logic [CTR_W-1:0] WT =
    CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] WNT = WT - 1'b1;
  localparam logic [CTR_W-1:0] CMAX = '1;

  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TAG_W-1:0] tag_d   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [31:0]      tgt_d   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_d   [ENTRIES];
  logic [STAT_W-1:0] cnt_q;
  logic [STAT_W-1:0] cnt_d;

  logic [IDX_W-1:0] lu_idx;
  logic [TAG_W-1:0] lu_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             lu_hit;
  logic             up_hit;
  logic [3:0]       unused_pc_bits;

  assign lu_idx = bus.lookup_pc[IDX_W+1:2];
  assign lu_tag = bus.lookup_pc[31:IDX_W+2];
  assign up_idx = bus.update_pc[IDX_W+1:2];
  assign up_tag = bus.update_pc[31:IDX_W+2];
  assign unused_pc_bits =
    {bus.lookup_pc[1:0], bus.update_pc[1:0]};

  assign lu_hit = valid_q[lu_idx] &&
                  (tag_q[lu_idx] == lu_tag);
  assign up_hit = valid_q[up_idx] &&
                  (tag_q[up_idx] == up_tag);

  assign bus.predict_hit   = lu_hit;
  assign bus.predict_taken = lu_hit &&
                             ctr_q[lu_idx][CTR_W-1];
  assign bus.predict_next_pc =
    bus.predict_taken ? tgt_q[lu_idx]
                      : bus.lookup_pc + 32'd4;
  assign bus.mispredict_cnt = cnt_q;

  // Training, allocation, clear and statistics next state.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    cnt_d   = cnt_q;
    if (bus.clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
        ctr_d[i]   = WNT;
      end
      cnt_d = '0;
    end else if (bus.update_en) begin
      if (up_hit) begin
        if (bus.update_taken) begin
          if (ctr_q[up_idx] != CMAX)
            ctr_d[up_idx] = ctr_q[up_idx] + 1'b1;
          tgt_d[up_idx] = bus.update_target;
        end else if (ctr_q[up_idx] != '0) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 1'b1;
        end
      end else if (bus.update_taken) begin
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = bus.update_target;
        ctr_d[up_idx]   = WT;
      end
      if (bus.update_mispredict && cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
    end
  end

  // Entry and statistics registers, async cleared.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= WNT;
      end
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
